// File: rtl/snake_body_engine_pkg.sv
// Shared definitions for the snake body engine:
// direction codes, FSM encodings, direction helper.
package snake_body_engine_pkg;

  localparam logic [1:0] DIR_XP = 2'b00;
  localparam logic [1:0] DIR_XN = 2'b01;
  localparam logic [1:0] DIR_YP = 2'b10;
  localparam logic [1:0] DIR_YN = 2'b11;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CALC   = 2'd1;
  localparam logic [1:0] ST_SCAN   = 2'd2;
  localparam logic [1:0] ST_COMMIT = 2'd3;

  // Opposite direction only flips the sign bit of the axis.
  function automatic logic [1:0] opposite_dir(input logic [1:0] d);
    return {d[1], ~d[0]};
  endfunction

endpackage

// File: rtl/snake_body_engine_next_head.sv
// Combinational head stepper with wrap-around and
// border detection for an arbitrary GRID_W x GRID_H.
module snake_next_head
  import snake_body_engine_pkg::*;
#(
  parameter int GRID_W = 8,
  parameter int GRID_H = 8,
  parameter int X_BITS = $clog2(GRID_W),
  parameter int Y_BITS = $clog2(GRID_H),
  parameter int POS_W  = X_BITS + Y_BITS
) (
  input  logic [POS_W-1:0] head,
  input  logic [1:0]       dir,
  input  logic             wall_mode,
  output logic [POS_W-1:0] nh,
  output logic             out_of_bounds
);

  localparam logic [X_BITS-1:0] X_MAX = X_BITS'(GRID_W - 1);
  localparam logic [Y_BITS-1:0] Y_MAX = Y_BITS'(GRID_H - 1);
  localparam logic [X_BITS-1:0] X_ONE = X_BITS'(1);
  localparam logic [Y_BITS-1:0] Y_ONE = Y_BITS'(1);

  logic [X_BITS-1:0] x;
  logic [X_BITS-1:0] nx;
  logic [Y_BITS-1:0] y;
  logic [Y_BITS-1:0] ny;
  logic              edge_hit;

  always_comb begin
    x        = head[X_BITS-1:0];
    y        = head[POS_W-1:X_BITS];
    nx       = x;
    ny       = y;
    edge_hit = 1'b0;
    unique case (dir)
      DIR_XP: begin
        edge_hit = (x == X_MAX);
        nx       = edge_hit ? '0 : x + X_ONE;
      end
      DIR_XN: begin
        edge_hit = (x == '0);
        nx       = edge_hit ? X_MAX : x - X_ONE;
      end
      DIR_YP: begin
        edge_hit = (y == Y_MAX);
        ny       = edge_hit ? '0 : y + Y_ONE;
      end
      DIR_YN: begin
        edge_hit = (y == '0);
        ny       = edge_hit ? Y_MAX : y - Y_ONE;
      end
    endcase
  end

  assign nh            = {ny, nx};
  assign out_of_bounds = edge_hit & wall_mode;

endmodule

// File: rtl/snake_body_engine.sv
// Snake body engine: circular body buffer, one move per
// request with serial self-collision scan before commit.
module snake_body_engine
  import snake_body_engine_pkg::*;
#(
  parameter int          GRID_W   = 8,
  parameter int          GRID_H   = 8,
  parameter int          MAX_LEN  = 64,
  parameter int          INIT_POS = 0,
  parameter logic [1:0]  INIT_DIR = 2'b00,
  parameter int          X_BITS   = $clog2(GRID_W),
  parameter int          Y_BITS   = $clog2(GRID_H),
  parameter int          POS_W    = X_BITS + Y_BITS,
  parameter int          LEN_W    = $clog2(MAX_LEN + 1)
) (
  input  logic             clock,
  input  logic             restart_n,
  input  logic             clear,
  input  logic             wall_mode,
  input  logic             move_req,
  input  logic [1:0]       dir,
  input  logic [POS_W-1:0] apple_pos,
  input  logic [LEN_W-1:0] rd_idx,
  output logic [POS_W-1:0] rd_pos,
  output logic [POS_W-1:0] head_pos,
  output logic [LEN_W-1:0] length,
  output logic             busy,
  output logic             done,
  output logic             ate,
  output logic             hit_wall,
  output logic             hit_self,
  output logic             full
);

  localparam int               PTR_W  = $clog2(MAX_LEN);
  localparam logic [POS_W-1:0] INIT_P = POS_W'(INIT_POS);
  localparam logic [LEN_W-1:0] LEN1   = LEN_W'(1);
  localparam logic [LEN_W-1:0] LENMAX = LEN_W'(MAX_LEN);

  logic [POS_W-1:0] body [MAX_LEN];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] prev_ptr;
  logic [1:0]       state;
  logic [1:0]       last_dir;
  logic [1:0]       eff_dir;
  logic [1:0]       eff_dir_q;
  logic             wall_q;
  logic [POS_W-1:0] apple_q;
  logic [POS_W-1:0] nh;
  logic [POS_W-1:0] nh_q;
  logic             oob;
  logic             grow;
  logic             grow_q;
  logic             ate_q;
  logic [LEN_W-1:0] n_scan;
  logic [LEN_W-1:0] scan_n;
  logic [LEN_W-1:0] scan_idx;

  // Segment i lives at (head_ptr + i) mod MAX_LEN.
  function automatic logic [PTR_W-1:0] seg_addr(
    input logic [PTR_W-1:0] hp,
    input logic [LEN_W-1:0] i
  );
    logic [LEN_W:0] s;
    s = (LEN_W+1)'(hp) + (LEN_W+1)'(i);
    if (s >= (LEN_W+1)'(MAX_LEN))
      s = s - (LEN_W+1)'(MAX_LEN);
    return s[PTR_W-1:0];
  endfunction

  snake_next_head #(
    .GRID_W(GRID_W),
    .GRID_H(GRID_H)
  ) u_next_head (
    .head         (head_pos),
    .dir          (eff_dir_q),
    .wall_mode    (wall_q),
    .nh           (nh),
    .out_of_bounds(oob)
  );

  assign head_pos = body[head_ptr];
  assign busy     = (state != ST_IDLE);
  assign full     = (length == LENMAX);
  assign prev_ptr = (head_ptr == '0) ? PTR_W'(MAX_LEN - 1)
                                     : head_ptr - PTR_W'(1);
  assign eff_dir  = (length > LEN1 && dir == opposite_dir(last_dir))
                    ? last_dir : dir;
  assign grow     = (nh == apple_q) && (length < LENMAX);
  assign n_scan   = grow ? length : length - LEN1;

  always_ff @(posedge clock or negedge restart_n) begin
    if (!restart_n) begin
      for (int i = 0; i < MAX_LEN; i++) body[i] <= '0;
      body[0]   <= INIT_P;
      head_ptr  <= '0;
      length    <= LEN1;
      last_dir  <= INIT_DIR;
      state     <= ST_IDLE;
      done      <= 1'b0;
      ate       <= 1'b0;
      hit_wall  <= 1'b0;
      hit_self  <= 1'b0;
      eff_dir_q <= '0;
      wall_q    <= 1'b0;
      apple_q   <= '0;
      nh_q      <= '0;
      grow_q    <= 1'b0;
      ate_q     <= 1'b0;
      scan_n    <= '0;
      scan_idx  <= '0;
    end else if (clear) begin
      body[0]  <= INIT_P;
      head_ptr <= '0;
      length   <= LEN1;
      last_dir <= INIT_DIR;
      state    <= ST_IDLE;
      done     <= 1'b0;
      ate      <= 1'b0;
      hit_wall <= 1'b0;
      hit_self <= 1'b0;
    end else begin
      done <= 1'b0;
      ate  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (move_req && !hit_wall && !hit_self) begin
            eff_dir_q <= eff_dir;
            wall_q    <= wall_mode;
            apple_q   <= apple_pos;
            state     <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (oob) begin
            hit_wall <= 1'b1;
            done     <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            nh_q     <= nh;
            grow_q   <= grow;
            ate_q    <= (nh == apple_q);
            scan_n   <= n_scan;
            scan_idx <= '0;
            state    <= (n_scan == '0) ? ST_COMMIT : ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (body[seg_addr(head_ptr, scan_idx)] == nh_q) begin
            hit_self <= 1'b1;
            done     <= 1'b1;
            ate      <= ate_q;
            state    <= ST_IDLE;
          end else if (scan_idx == scan_n - LEN1) begin
            state <= ST_COMMIT;
          end else begin
            scan_idx <= scan_idx + LEN1;
          end
        end
        ST_COMMIT: begin
          head_ptr       <= prev_ptr;
          body[prev_ptr] <= nh_q;
          length         <= length + LEN_W'(grow_q);
          last_dir       <= eff_dir_q;
          done           <= 1'b1;
          ate            <= ate_q;
          state          <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge restart_n) begin
    if (!restart_n)
      rd_pos <= '0;
    else if (rd_idx < length)
      rd_pos <= body[seg_addr(head_ptr, rd_idx)];
    else
      rd_pos <= '0;
  end

endmodule

// File: tb/tb_snake_body_engine.sv
// Directed bench: three engine configurations sharing one
// stimulus bus, each scenario checks one instance.
module tb_snake_body_engine;

  logic       clock;
  logic       restart_n;
  logic       clear;
  logic       wall_mode;
  logic       move_req;
  logic [1:0] dir;
  logic [5:0] apple_pos;
  logic [6:0] rd_idx;

  logic [5:0] rd_pos_a, head_a, rd_pos_b, head_b, rd_pos_c, head_c;
  logic [6:0] len_a, len_b;
  logic [2:0] len_c;
  logic busy_a, done_a, ate_a, hw_a, hs_a, full_a;
  logic busy_b, done_b, ate_b, hw_b, hs_b, full_b;
  logic busy_c, done_c, ate_c, hw_c, hs_c, full_c;

  int passed = 0;
  int total  = 0;
  int lat;

  localparam logic [5:0] NO_APPLE = 6'd63;

  snake_body_engine #(.GRID_W(8), .GRID_H(8), .MAX_LEN(64),
    .INIT_POS(27), .INIT_DIR(2'b00)) u_a (
    .clock(clock), .restart_n(restart_n), .clear(clear),
    .wall_mode(wall_mode), .move_req(move_req), .dir(dir),
    .apple_pos(apple_pos), .rd_idx(rd_idx), .rd_pos(rd_pos_a),
    .head_pos(head_a), .length(len_a), .busy(busy_a),
    .done(done_a), .ate(ate_a), .hit_wall(hw_a),
    .hit_self(hs_a), .full(full_a));

  snake_body_engine #(.GRID_W(5), .GRID_H(6), .MAX_LEN(64),
    .INIT_POS(0), .INIT_DIR(2'b00)) u_b (
    .clock(clock), .restart_n(restart_n), .clear(clear),
    .wall_mode(wall_mode), .move_req(move_req), .dir(dir),
    .apple_pos(apple_pos), .rd_idx(rd_idx), .rd_pos(rd_pos_b),
    .head_pos(head_b), .length(len_b), .busy(busy_b),
    .done(done_b), .ate(ate_b), .hit_wall(hw_b),
    .hit_self(hs_b), .full(full_b));

  snake_body_engine #(.GRID_W(8), .GRID_H(8), .MAX_LEN(4),
    .INIT_POS(27), .INIT_DIR(2'b00)) u_c (
    .clock(clock), .restart_n(restart_n), .clear(clear),
    .wall_mode(wall_mode), .move_req(move_req), .dir(dir),
    .apple_pos(apple_pos), .rd_idx(rd_idx[2:0]), .rd_pos(rd_pos_c),
    .head_pos(head_c), .length(len_c), .busy(busy_c),
    .done(done_c), .ate(ate_c), .hit_wall(hw_c),
    .hit_self(hs_c), .full(full_c));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic g_done(input int k);
    case (k)
      0: return done_a;
      1: return done_b;
      default: return done_c;
    endcase
  endfunction

  // Inputs change 1 time unit after a rising edge; so do samples.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic do_move(input int k, input logic [1:0] d,
                         input logic [5:0] ap, input logic wm,
                         output int l);
    dir       = d;
    apple_pos = ap;
    wall_mode = wm;
    move_req  = 1'b1;
    tick();
    move_req = 1'b0;
    l = 0;
    for (int c = 1; c <= 100; c++) begin
      tick();
      if (g_done(k)) begin
        l = c;
        break;
      end
    end
    total++;
    if (l == 0) $display("FAIL move_timeout inst %0d: no done in 100 cycles", k);
    else passed++;
  endtask

  task automatic test_reset();
    total++; if (len_a !== 7'd1) $display("FAIL rst_len got %0d want 1", len_a); else passed++;
    total++; if (head_a !== 6'd27) $display("FAIL rst_head got %0d want 27", head_a); else passed++;
    total++; if ({busy_a, done_a, ate_a, hw_a, hs_a, full_a} !== 6'b0)
      $display("FAIL rst_flags got %b want 000000", {busy_a, done_a, ate_a, hw_a, hs_a, full_a}); else passed++;
    total++; if (rd_pos_a !== 6'd0) $display("FAIL rst_rdpos got %0d want 0", rd_pos_a); else passed++;
    tick();
    total++; if (rd_pos_a !== 6'd27) $display("FAIL rst_rd0 got %0d want 27", rd_pos_a); else passed++;
  endtask

  task automatic test_basic_move();
    do_clear();
    do_move(0, 2'b00, 6'd0, 1'b0, lat);
    total++; if (lat !== 2) $display("FAIL mv1_lat got %0d want 2", lat); else passed++;
    total++; if (head_a !== 6'd28) $display("FAIL mv1_head got %0d want 28", head_a); else passed++;
    total++; if (len_a !== 7'd1) $display("FAIL mv1_len got %0d want 1", len_a); else passed++;
    total++; if (ate_a !== 1'b0) $display("FAIL mv1_ate got %b want 0", ate_a); else passed++;
    do_move(0, 2'b00, 6'd29, 1'b0, lat);
    total++; if (lat !== 3) $display("FAIL eat_lat got %0d want 3", lat); else passed++;
    total++; if (ate_a !== 1'b1) $display("FAIL eat_ate got %b want 1", ate_a); else passed++;
    total++; if (len_a !== 7'd2) $display("FAIL eat_len got %0d want 2", len_a); else passed++;
    do_move(0, 2'b01, NO_APPLE, 1'b0, lat);
    total++; if (head_a !== 6'd30) $display("FAIL rev_head got %0d want 30", head_a); else passed++;
    total++; if (len_a !== 7'd2) $display("FAIL rev_len got %0d want 2", len_a); else passed++;
    rd_idx = 7'd1;
    tick();
    total++; if (rd_pos_a !== 6'd29) $display("FAIL rd1 got %0d want 29", rd_pos_a); else passed++;
    rd_idx = 7'd2;
    tick();
    total++; if (rd_pos_a !== 6'd0) $display("FAIL rd_oob got %0d want 0", rd_pos_a); else passed++;
    rd_idx = 7'd0;
  endtask

  task automatic test_wall();
    do_clear();
    repeat (4) do_move(0, 2'b00, NO_APPLE, 1'b0, lat);
    total++; if (head_a !== 6'd31) $display("FAIL wall_pre got %0d want 31", head_a); else passed++;
    do_move(0, 2'b00, NO_APPLE, 1'b1, lat);
    total++; if (lat !== 1) $display("FAIL wall_lat got %0d want 1", lat); else passed++;
    total++; if (hw_a !== 1'b1) $display("FAIL wall_hit got %b want 1", hw_a); else passed++;
    total++; if (head_a !== 6'd31) $display("FAIL wall_head got %0d want 31", head_a); else passed++;
    dir = 2'b10; move_req = 1'b1;
    tick();
    move_req = 1'b0;
    total++; if (busy_a !== 1'b0) $display("FAIL wall_ignore got busy %b want 0", busy_a); else passed++;
    repeat (3) tick();
    total++; if (head_a !== 6'd31) $display("FAIL wall_stay got %0d want 31", head_a); else passed++;
    do_clear();
    total++; if (hw_a !== 1'b0) $display("FAIL wall_clr got %b want 0", hw_a); else passed++;
  endtask

  task automatic test_wrap();
    do_clear();
    repeat (3) do_move(0, 2'b11, NO_APPLE, 1'b0, lat);
    repeat (4) do_move(0, 2'b00, NO_APPLE, 1'b0, lat);
    total++; if (head_a !== 6'd7) $display("FAIL wrapA_pre got %0d want 7", head_a); else passed++;
    do_move(0, 2'b00, NO_APPLE, 1'b0, lat);
    total++; if (head_a !== 6'd0) $display("FAIL wrapA_x got %0d want 0", head_a); else passed++;
    do_move(0, 2'b11, NO_APPLE, 1'b0, lat);
    total++; if (head_a !== 6'd56) $display("FAIL wrapA_y got %0d want 56", head_a); else passed++;
    do_clear();
    do_move(1, 2'b01, NO_APPLE, 1'b0, lat);
    total++; if (head_b !== 6'd4) $display("FAIL wrapB_xn got %0d want 4", head_b); else passed++;
    do_move(1, 2'b11, NO_APPLE, 1'b0, lat);
    total++; if (head_b !== 6'd44) $display("FAIL wrapB_yn got %0d want 44", head_b); else passed++;
    do_move(1, 2'b00, NO_APPLE, 1'b0, lat);
    total++; if (head_b !== 6'd40) $display("FAIL wrapB_xp got %0d want 40", head_b); else passed++;
    do_move(1, 2'b10, NO_APPLE, 1'b0, lat);
    total++; if (head_b !== 6'd0) $display("FAIL wrapB_yp got %0d want 0", head_b); else passed++;
    do_move(1, 2'b11, NO_APPLE, 1'b1, lat);
    total++; if (hw_b !== 1'b1 || head_b !== 6'd0)
      $display("FAIL wallB got hit %b head %0d want hit 1 head 0", hw_b, head_b); else passed++;
  endtask

  task automatic test_self_hit();
    do_clear();
    do_move(0, 2'b00, 6'd28, 1'b0, lat);
    do_move(0, 2'b00, 6'd29, 1'b0, lat);
    do_move(0, 2'b00, 6'd30, 1'b0, lat);
    do_move(0, 2'b00, 6'd31, 1'b0, lat);
    total++; if (len_a !== 7'd5) $display("FAIL self_len got %0d want 5", len_a); else passed++;
    do_move(0, 2'b10, NO_APPLE, 1'b0, lat);
    do_move(0, 2'b01, NO_APPLE, 1'b0, lat);
    total++; if (head_a !== 6'd38) $display("FAIL self_pre got %0d want 38", head_a); else passed++;
    do_move(0, 2'b11, NO_APPLE, 1'b0, lat);
    total++; if (hs_a !== 1'b1) $display("FAIL self_hit got %b want 1", hs_a); else passed++;
    total++; if (lat !== 5) $display("FAIL self_lat got %0d want 5", lat); else passed++;
    total++; if (head_a !== 6'd38 || len_a !== 7'd5)
      $display("FAIL self_state got head %0d len %0d want 38 5", head_a, len_a); else passed++;
  endtask

  task automatic test_tail_chase();
    do_clear();
    do_move(0, 2'b00, 6'd28, 1'b0, lat);
    do_move(0, 2'b00, 6'd29, 1'b0, lat);
    do_move(0, 2'b00, 6'd30, 1'b0, lat);
    do_move(0, 2'b10, NO_APPLE, 1'b0, lat);
    do_move(0, 2'b01, NO_APPLE, 1'b0, lat);
    do_move(0, 2'b11, NO_APPLE, 1'b0, lat);
    total++; if (hs_a !== 1'b0) $display("FAIL tail_hit got %b want 0", hs_a); else passed++;
    total++; if (lat !== 5) $display("FAIL tail_lat got %0d want 5", lat); else passed++;
    total++; if (head_a !== 6'd29 || len_a !== 7'd4)
      $display("FAIL tail_state got head %0d len %0d want 29 4", head_a, len_a); else passed++;
  endtask

  task automatic test_full_and_clear();
    logic seen;
    do_clear();
    do_move(2, 2'b00, 6'd28, 1'b0, lat);
    do_move(2, 2'b00, 6'd29, 1'b0, lat);
    do_move(2, 2'b00, 6'd30, 1'b0, lat);
    total++; if (len_c !== 3'd4 || full_c !== 1'b1)
      $display("FAIL full_pre got len %0d full %b want 4 1", len_c, full_c); else passed++;
    do_move(2, 2'b00, 6'd31, 1'b0, lat);
    total++; if (ate_c !== 1'b1) $display("FAIL full_ate got %b want 1", ate_c); else passed++;
    total++; if (len_c !== 3'd4) $display("FAIL full_len got %0d want 4", len_c); else passed++;
    total++; if (head_c !== 6'd31) $display("FAIL full_head got %0d want 31", head_c); else passed++;
    total++; if (lat !== 5) $display("FAIL full_lat got %0d want 5", lat); else passed++;
    rd_idx = 7'd3;
    tick();
    total++; if (rd_pos_c !== 6'd28) $display("FAIL full_rd3 got %0d want 28", rd_pos_c); else passed++;
    rd_idx = 7'd0;
    dir = 2'b10; apple_pos = NO_APPLE; wall_mode = 1'b0; move_req = 1'b1;
    tick();
    move_req = 1'b0;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      tick();
      if (done_c) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) $display("FAIL clr_done got %b want 0", seen); else passed++;
    total++; if (len_c !== 3'd1 || head_c !== 6'd27 || busy_c !== 1'b0)
      $display("FAIL clr_state got len %0d head %0d busy %b want 1 27 0", len_c, head_c, busy_c);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic seen;
    do_clear();
    dir = 2'b00; apple_pos = NO_APPLE; wall_mode = 1'b0; move_req = 1'b1;
    tick();
    total++; if (busy_a !== 1'b1) $display("FAIL b2b_busy got %b want 1", busy_a); else passed++;
    dir = 2'b10;
    tick();
    move_req = 1'b0;
    tick();
    total++; if (done_a !== 1'b1 || head_a !== 6'd28)
      $display("FAIL b2b_done got done %b head %0d want 1 28", done_a, head_a); else passed++;
    seen = 1'b0;
    repeat (4) begin
      tick();
      if (done_a || busy_a) seen = 1'b1;
    end
    total++; if (seen !== 1'b0 || head_a !== 6'd28)
      $display("FAIL b2b_drop got activity %b head %0d want 0 28", seen, head_a); else passed++;
  endtask

  initial begin
    restart_n = 1'b0;
    clear     = 1'b0;
    wall_mode = 1'b0;
    move_req  = 1'b0;
    dir       = 2'b00;
    apple_pos = 6'd0;
    rd_idx    = 7'd0;
    repeat (2) @(posedge clock);
    #1;
    restart_n = 1'b1;
    test_reset();
    test_basic_move();
    test_wall();
    test_wrap();
    test_self_hit();
    test_tail_chase();
    test_full_and_clear();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
